// File: rtl/seg_scan_parity_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_parity_if
// Brief    : Write port, error and display signals of seg_scan_parity.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_scan_parity_if #(
    parameter int DIGITS = 4,
    parameter int DATA_W = 5
);
    localparam int c_ADDR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                en;
    logic                wr_valid;
    logic                wr_ready;
    logic [c_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_par;
    logic                clr_err;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                err_flag;
    logic [7:0]          err_cnt;

    modport master (
        output en, wr_valid, wr_addr, wr_data, wr_par, clr_err,
        input  wr_ready, seg, an, err_flag, err_cnt
    );

    modport slave (
        input  en, wr_valid, wr_addr, wr_data, wr_par, clr_err,
        output wr_ready, seg, an, err_flag, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_parity.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_parity
// Brief    : Multiplexed 7-segment scanner with parity-checked digit writes.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_parity #(
    parameter int DIGITS       = 4,
    parameter int DATA_W       = 5,
    parameter int MAX_VAL      = 15,
    parameter int ODD_PAR      = 0,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input wire          clk,
    input wire          rst,
    seg_scan_parity_if.slave bus
);
    localparam int c_ADDR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_FRM_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [1:0] c_K_EMPTY = 2'd0;
    localparam logic [1:0] c_K_OK    = 2'd1;
    localparam logic [1:0] c_K_RANGE = 2'd2;
    localparam logic [1:0] c_K_PERR  = 2'd3;

    localparam logic [DIGITS-1:0] c_AN_ONE = DIGITS'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [c_ADDR_W-1:0] r_idx, w_idx_nxt;
    logic [c_FRM_W-1:0]  r_frm, w_frm_nxt;
    logic                r_blink, w_blink_nxt;

    logic [1:0]          r_kind [DIGITS];
    logic [3:0]          r_val  [DIGITS];
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_err_flag;
    logic [7:0]          r_err_cnt;

    logic                w_accept;
    logic                w_par_ok;
    logic [1:0]          w_kind_in;

    assign bus.wr_ready = ~rst;
    assign bus.seg      = r_seg;
    assign bus.an       = r_an;
    assign bus.err_flag = r_err_flag;
    assign bus.err_cnt  = r_err_cnt;

    assign w_accept  = bus.wr_valid & bus.wr_ready;
    assign w_par_ok  = ((^bus.wr_data) ^ bus.wr_par) == 1'(ODD_PAR);
    assign w_kind_in = !w_par_ok                          ? c_K_PERR  :
                       (bus.wr_data > DATA_W'(MAX_VAL))   ? c_K_RANGE : c_K_OK;

    function automatic logic [6:0] f_glyph(input logic [1:0] kind, input logic [3:0] val,
                                           input logic blink);
        logic [6:0] g;
        g = 7'h00;
        case (kind)
            c_K_OK: begin
                case (val)
                    4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
                    4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
                    4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
                    4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
                endcase
            end
            c_K_RANGE: g = 7'h01;
            c_K_PERR:  g = blink ? 7'h4F : 7'h00;
            default:   g = 7'h00;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_frm   <= '0;
            r_blink <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_frm   <= w_frm_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        w_idx_nxt   = r_idx;
        w_frm_nxt   = r_frm;
        w_blink_nxt = r_blink;
        if (!bus.en) begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                end
                ST_GUARD: begin
                    if (r_cnt == c_CNT_W'(GUARD_CYC - 1)) begin
                        w_state_nxt = ST_DRIVE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == c_CNT_W'(SCAN_DIV - 1)) begin
                        w_state_nxt = ST_GUARD;
                        w_cnt_nxt   = '0;
                        // Blink phase advances only on full-frame wraps of the digit index
                        if (r_idx == c_ADDR_W'(DIGITS - 1)) begin
                            w_idx_nxt = '0;
                            if (r_frm == c_FRM_W'(BLINK_FRAMES - 1)) begin
                                w_frm_nxt   = '0;
                                w_blink_nxt = ~r_blink;
                            end else begin
                                w_frm_nxt = r_frm + c_FRM_W'(1);
                            end
                        end else begin
                            w_idx_nxt = r_idx + c_ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Addresses beyond the last digit match no slot and are dropped here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                r_kind[i] <= c_K_EMPTY;
                r_val[i]  <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bus.wr_addr == c_ADDR_W'(i)) begin
                    r_kind[i] <= w_kind_in;
                    if (w_kind_in == c_K_OK) begin
                        r_val[i] <= bus.wr_data[3:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= 7'h7F;
            r_an  <= '1;
        end else if (w_state_nxt == ST_DRIVE) begin
            r_seg <= ~f_glyph(r_kind[w_idx_nxt], r_val[w_idx_nxt], w_blink_nxt);
            r_an  <= ~(c_AN_ONE << w_idx_nxt);
        end else begin
            r_seg <= 7'h7F;
            r_an  <= '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else if (w_accept && !w_par_ok) begin
            r_err_flag <= 1'b1;
            if (bus.clr_err) begin
                r_err_cnt <= 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (bus.clr_err) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_parity
// Brief    : Directed plus random stimulus against a cycle-level display model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_parity;
    localparam int D    = 4;
    localparam int DW   = 5;
    localparam int MAXV = 15;
    localparam int ODD  = 0;
    localparam int SDIV = 4;
    localparam int GC   = 1;
    localparam int BF   = 2;
    localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg_scan_parity_if #(.DIGITS(D), .DATA_W(DW)) ifc ();

    seg_scan_parity #(
        .DIGITS(D), .DATA_W(DW), .MAX_VAL(MAXV), .ODD_PAR(ODD),
        .SCAN_DIV(SDIV), .GUARD_CYC(GC), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 empty, 1 value, 2 out of range, 3 parity error
    bit       m_on;
    int       m_p, m_d, m_wraps;
    bit       m_blink;
    int       m_kind [D];
    int       m_val  [D];
    bit       m_eflag;
    int       m_ecnt;
    logic [6:0]   e_seg;
    logic [D-1:0] e_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_p = 0; m_d = 0; m_wraps = 0; m_blink = 1;
        for (int i = 0; i < D; i++) begin
            m_kind[i] = 0;
            m_val[i]  = 0;
        end
        m_eflag = 0; m_ecnt = 0;
        e_seg = 7'h7F; e_an = '1;
    endtask

    function automatic logic [6:0] model_glyph(input int d);
        case (m_kind[d])
            1:       return GLYPH[m_val[d]];
            2:       return 7'h01;
            3:       return m_blink ? 7'h4F : 7'h00;
            default: return 7'h00;
        endcase
    endfunction

    task automatic model_edge();
        int  a, dv;
        bit  pbad;
        if (rst) begin
            model_reset();
            return;
        end
        if (!ifc.en) begin
            m_on = 0;
        end else if (!m_on) begin
            m_on = 1;
            m_p  = 0;
        end else begin
            m_p++;
            if (m_p == GC + SDIV) begin
                m_p = 0;
                m_d = (m_d + 1) % D;
                if (m_d == 0) begin
                    m_wraps++;
                    if (m_wraps == BF) begin
                        m_wraps = 0;
                        m_blink = !m_blink;
                    end
                end
            end
        end
        e_an  = '1;
        e_seg = 7'h7F;
        if (m_on && m_p >= GC) begin
            e_an[m_d] = 1'b0;
            e_seg     = ~model_glyph(m_d);
        end
        if (ifc.wr_valid) begin
            a    = int'(ifc.wr_addr);
            dv   = int'(ifc.wr_data);
            pbad = (($countones(ifc.wr_data) + int'(ifc.wr_par)) % 2) != ODD;
            if (pbad) begin
                m_eflag = 1;
                m_ecnt  = ifc.clr_err ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
            end else if (ifc.clr_err) begin
                m_eflag = 0;
                m_ecnt  = 0;
            end
            if (a < D) begin
                if (pbad)           m_kind[a] = 3;
                else if (dv > MAXV) m_kind[a] = 2;
                else begin
                    m_kind[a] = 1;
                    m_val[a]  = dv;
                end
            end
        end else if (ifc.clr_err) begin
            m_eflag = 0;
            m_ecnt  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("seg",      32'(ifc.seg),      32'(e_seg));
        check("an",       32'(ifc.an),       32'(e_an));
        check("err_flag", 32'(ifc.err_flag), 32'(m_eflag));
        check("err_cnt",  32'(ifc.err_cnt),  32'(m_ecnt));
        check("wr_ready", 32'(ifc.wr_ready), 32'(!rst));
    endtask

    task automatic wr(input int addr, input int data, input bit par);
        ifc.wr_valid = 1'b1;
        ifc.wr_addr  = 2'(addr);
        ifc.wr_data  = 5'(data);
        ifc.wr_par   = par;
        tick();
        ifc.wr_valid = 1'b0;
    endtask

    function automatic bit good_par(input int data);
        return bit'(($countones(5'(data)) + ODD) % 2);
    endfunction

    initial begin
        bit found;
        int dv;
        ifc.en = 1'b0; ifc.wr_valid = 1'b0; ifc.wr_addr = '0;
        ifc.wr_data = '0; ifc.wr_par = 1'b0; ifc.clr_err = 1'b0;
        model_reset();

        repeat (3) tick();
        rst = 1'b0;
        tick();
        ifc.en = 1'b1;
        repeat (45) tick();

        wr(0, 3, 1'b0);
        repeat (25) tick();
        wr(0, 3, 1'b1);
        check("perr_flag", 32'(ifc.err_flag), 32'd1);
        check("perr_cnt",  32'(ifc.err_cnt),  32'd1);
        repeat (100) tick();

        wr(1, 20, 1'b0);
        check("range_cnt", 32'(ifc.err_cnt), 32'd1);
        repeat (25) tick();

        for (int i = 0; i < 600; i++) begin
            ifc.en       = ($urandom_range(0, 19) != 0);
            ifc.clr_err  = ($urandom_range(0, 29) == 0);
            ifc.wr_valid = ($urandom_range(0, 2) == 0);
            ifc.wr_addr  = 2'($urandom_range(0, D - 1));
            dv           = int'($urandom_range(0, 31));
            ifc.wr_data  = 5'(dv);
            ifc.wr_par   = good_par(dv) ^ ($urandom_range(0, 3) == 0);
            tick();
        end
        ifc.en = 1'b1; ifc.clr_err = 1'b0; ifc.wr_valid = 1'b0;

        ifc.clr_err = 1'b1;
        tick();
        ifc.clr_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            dv = int'($urandom_range(0, 31));
            wr(i % D, dv, !good_par(dv));
        end
        check("sat_cnt",  32'(ifc.err_cnt),  32'd255);
        check("sat_flag", 32'(ifc.err_flag), 32'd1);
        ifc.clr_err = 1'b1;
        wr(2, 6, 1'b1);
        ifc.clr_err = 1'b0;
        check("clr_bad_cnt",  32'(ifc.err_cnt),  32'd1);
        check("clr_bad_flag", 32'(ifc.err_flag), 32'd1);

        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_on && m_d == 3 && m_p == GC) found = 1;
            else tick();
        end
        check("wait_drive3", 32'(found), 32'd1);
        wr(3, 7, good_par(7));
        tick();
        check("drive3_update", 32'(ifc.seg), 32'(7'h0F));
        ifc.en = 1'b0;
        tick();
        check("en_off_an", 32'(ifc.an), 32'hF);
        ifc.en = 1'b1;
        repeat (30) tick();

        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (m_on && m_p > GC) found = 1;
            else tick();
        end
        check("wait_drive", 32'(found), 32'd1);
        ifc.wr_valid = 1'b1; ifc.wr_addr = 2'd2; ifc.wr_data = 5'd5; ifc.wr_par = good_par(5);
        #2 rst = 1'b1;
        #1;
        check("async_seg",      32'(ifc.seg),      32'h7F);
        check("async_an",       32'(ifc.an),       32'hF);
        check("async_err_flag", 32'(ifc.err_flag), 32'd0);
        check("async_err_cnt",  32'(ifc.err_cnt),  32'd0);
        check("async_wr_ready", 32'(ifc.wr_ready), 32'd0);
        model_reset();
        tick();
        ifc.wr_valid = 1'b0;
        tick();
        rst = 1'b0;
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/seg_scan_parity.md
SEG_SCAN_PARITY -- requirements
Module: seg_scan_parity

Interface
REQ-001 Parameter DIGITS, 4, number of multiplexed 7-segment digits (1..8).
REQ-002 Parameter DATA_W, 5, width of each written value (4..8).
REQ-003 Parameter MAX_VAL, 15, largest displayable value (MAX_VAL <= 15).
REQ-004 Parameter ODD_PAR, 0, parity sense: 0 = even, 1 = odd.
REQ-005 Parameter SCAN_DIV, 1000, cycles each digit is driven per slot.
REQ-006 Parameter GUARD_CYC, 2, anti-ghost blank cycles before each slot.
REQ-007 Parameter BLINK_FRAMES, 64, full scan frames per blink half-period.
REQ-008 clk  in  1  single clock, rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 en  in  1  scan enable.
REQ-011 wr_valid  in  1  write request.
REQ-012 wr_ready  out  1  write accept.
REQ-013 wr_addr  in  clog2(DIGITS) (minimum 1)  target digit.
REQ-014 wr_data  in  DATA_W  value to display.
REQ-015 wr_par  in  1  parity bit for wr_data.
REQ-016 clr_err  in  1  clears the error flag and error counter.
REQ-017 seg  out  7  active-low segments, seg[6]=A ... seg[0]=G.
REQ-018 an  out  DIGITS  active-low one-hot digit enable.
REQ-019 err_flag  out  1  sticky parity-error flag.
REQ-020 err_cnt  out  8  saturating parity-error count.

Function
REQ-021 A write SHALL be accepted on any rising edge with wr_valid=1 and wr_ready=1; wr_ready SHALL be 1 whenever rst=0.
REQ-022 On an accepted write to wr_addr < DIGITS, the addressed digit SHALL store a status on the next edge: PERR if the parity check fails, otherwise RANGE if wr_data > MAX_VAL, otherwise OK together with the value.
REQ-023 The parity check SHALL pass when XOR(wr_data, wr_par) equals ODD_PAR.
REQ-024 A write with wr_addr >= DIGITS SHALL be accepted and discarded, with no effect on any status or error output.
REQ-025 Each accepted write that fails the parity check SHALL set err_flag on the next edge and increment err_cnt, which saturates at 255; this applies to all addresses, including wr_addr >= DIGITS.
REQ-026 clr_err=1 SHALL clear err_flag and err_cnt on the next edge; if a parity-failing write is accepted in the same cycle, the result SHALL be err_flag=1 and err_cnt=1.
REQ-027 The FSM SHALL have three states: OFF, GUARD and DRIVE.
REQ-028 OFF SHALL go to GUARD when en=1.
REQ-029 GUARD SHALL go to DRIVE after GUARD_CYC cycles.
REQ-030 DRIVE SHALL go to GUARD after SCAN_DIV cycles, advancing the digit index 0->1->...->DIGITS-1->0.
REQ-031 en=0 in any state SHALL force OFF on the next edge; the digit index and blink state are held.
REQ-032 In OFF and GUARD, an SHALL be all 1 and seg SHALL be 7'h7F.
REQ-033 In DRIVE, an[index] SHALL be 0 and all other an bits 1; seg SHALL be ~glyph of the current digit.
REQ-034 Glyph values (active-high, A..G):
 - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
 - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
 - RANGE: 01 (dash)
 - EMPTY: 00
 - PERR: 4F ("E") in blink-on phase, 00 in blink-off phase
REQ-035 The blink phase SHALL toggle each time BLINK_FRAMES index wraps from DIGITS-1 to 0 have been counted.
REQ-036 seg and an SHALL be registered outputs; a write becomes visible at the next DRIVE entry of its digit, or immediately if that digit is in DRIVE (one-cycle latency).
REQ-037 Writes SHALL be accepted in every FSM state, including OFF.

Reset
REQ-038 While rst=1, the block SHALL hold:
 - seg=7'h7F, an all 1
 - err_flag=0, err_cnt=0, wr_ready=0
 - all digits EMPTY
 - state OFF, digit index 0, blink phase on, all counters 0
REQ-039 Reset asserted mid-slot or mid-write SHALL take effect asynchronously; the interrupted write SHALL be lost.

Verification (DIGITS=4, DATA_W=5, SCAN_DIV=4, GUARD_CYC=1, BLINK_FRAMES=2, ODD_PAR=0)
REQ-040 After reset, en=1: an sequence 1110,1101,1011,0111 with 4 cycles each, separated by 1-cycle 1111 gaps; seg=7F throughout.
REQ-041 Write addr0 data 5'd3 par 0 -> digit 0 seg=~79=06; write data 5'd3 par 1 -> digit 0 shows ~4F in on phase and 7F in off phase, toggling every 2 frames; err_flag=1, err_cnt=1.
REQ-042 Write addr1 data 5'd20 par 0 -> digit 1 seg=~01=7E; err_cnt unchanged.
REQ-043 256 parity-bad writes -> err_cnt=255; clr_err together with one more bad write -> err_cnt=1, err_flag=1.
REQ-044 Write to addr 3 while it is driven -> seg changes on the next cycle; en=0 mid-DRIVE -> an=1111 on the next edge; rst pulse mid-DRIVE -> all outputs reach reset values without a clock edge.
